// File: rtl/avalon_cipher_dma.sv
// Avalon memory-to-memory DMA that encrypts 64-bit blocks with PRESENT-128 in ECB or CBC mode.
// Holds the iterative PRESENT core (one round per clock) and the DMA register/bus engine.

module present (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [63:0]  plaintext,
   input  logic [127:0] key,
   output logic [63:0]  ciphertext,
   output logic         eoc
);

   logic [63:0]  state_r;
   logic [127:0] key_r;
   logic [5:0]   round_r;
   logic         run_r;
   logic [63:0]  ciphertext_r;
   logic         eoc_r;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
         4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
         4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
         4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;
         default: sbox = 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
      return y;
   endfunction

   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 63; i++) y[(i * 16) % 63] = x[i];
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [127:0] key_update(input logic [127:0] k, input logic [4:0] rc);
      logic [127:0] y;
      y            = {k[66:0], k[127:67]};
      y[127:124]   = sbox(y[127:124]);
      y[123:120]   = sbox(y[123:120]);
      y[66:62]     = y[66:62] ^ rc;
      return y;
   endfunction

   // Round engine: rounds 1..31 update state and key, round 32 applies the final whitening key.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= 64'h0;
         key_r        <= 128'h0;
         round_r      <= 6'd0;
         run_r        <= 1'b0;
         ciphertext_r <= 64'h0;
         eoc_r        <= 1'b0;
      end else begin
         eoc_r <= 1'b0;
         if (start) begin
            state_r <= plaintext;
            key_r   <= key;
            round_r <= 6'd1;
            run_r   <= 1'b1;
         end else if (run_r) begin
            if (round_r == 6'd32) begin
               ciphertext_r <= state_r ^ key_r[127:64];
               eoc_r        <= 1'b1;
               run_r        <= 1'b0;
            end else begin
               state_r <= p_layer(s_layer(state_r ^ key_r[127:64]));
               key_r   <= key_update(key_r, round_r[4:0]);
               round_r <= round_r + 6'd1;
            end
         end
      end
   end

   assign ciphertext = ciphertext_r;
   assign eoc        = eoc_r;

endmodule

module avalon_cipher_dma #(
   parameter int CNT_W  = 16,
   parameter bit CBC_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        avs_write,
   input  logic [5:0]  avs_address,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_address,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        irq
);

   typedef enum logic [2:0] {
      IDLE = 3'd0, RD0 = 3'd1, RD1 = 3'd2, ENC_START = 3'd3,
      ENC_WAIT = 3'd4, WR0 = 3'd5, WR1 = 3'd6, FINISH = 3'd7
   } state_t;

   state_t           state_r, nxt_state_s;
   logic [127:0]     key_r;
   logic [31:0]      src_r, dst_r, iv_hi_r, iv_lo_r;
   logic [CNT_W-1:0] num_r, remaining_r, done_cnt_r;
   logic             mode_r, irq_en_r, done_r, aborted_r, abort_pending_r, irq_r;
   logic [31:0]      rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
   logic [63:0]      pt_r, chain_r, ct_s, cipher_pt_s;
   logic             eoc_s, cipher_start_s;
   logic             avm_read_r, avm_write_r, avm_read_nxt_s, avm_write_nxt_s;
   logic [31:0]      avm_address_r, avm_writedata_r, avm_address_nxt_s, avm_writedata_nxt_s;
   logic [3:0]       reg_idx_s;
   logic             busy_s, hs_s, cfg_wr_s, start_s, abort_wr_s, w1c_s, fin_s, last_blk_s;
   logic             unused_s;

   assign reg_idx_s  = avs_address[5:2];
   assign unused_s   = ^avs_address[1:0];
   assign busy_s     = (state_r != IDLE);
   assign hs_s       = ~avm_waitrequest;
   assign cfg_wr_s   = avs_write & ~busy_s;
   assign start_s    = cfg_wr_s & (reg_idx_s == 4'd7) & avs_writedata[0];
   assign abort_wr_s = avs_write & busy_s & (reg_idx_s == 4'd7) & avs_writedata[3];
   assign w1c_s      = avs_write & (reg_idx_s == 4'd8);
   assign fin_s      = (state_r == FINISH);
   assign last_blk_s = (remaining_r == CNT_W'(32'd1));

   assign cipher_start_s = (state_r == ENC_START);
   assign cipher_pt_s    = mode_r ? (pt_r ^ chain_r) : pt_r;

   present u_present (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (cipher_start_s),
      .plaintext  (cipher_pt_s),
      .key        (key_r),
      .ciphertext (ct_s),
      .eoc        (eoc_s)
   );

   // Configuration registers; frozen while a transfer is running.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_r    <= 128'h0;
         src_r    <= 32'h0;
         dst_r    <= 32'h0;
         num_r    <= {CNT_W{1'b0}};
         mode_r   <= 1'b0;
         irq_en_r <= 1'b0;
         iv_hi_r  <= 32'h0;
         iv_lo_r  <= 32'h0;
      end else if (cfg_wr_s) begin
         case (reg_idx_s)
            4'd0:  key_r[31:0]   <= avs_writedata;
            4'd1:  key_r[63:32]  <= avs_writedata;
            4'd2:  key_r[95:64]  <= avs_writedata;
            4'd3:  key_r[127:96] <= avs_writedata;
            4'd4:  src_r         <= avs_writedata;
            4'd5:  dst_r         <= avs_writedata;
            4'd6:  num_r         <= avs_writedata[CNT_W-1:0];
            4'd7: begin
               mode_r   <= CBC_EN ? avs_writedata[1] : 1'b0;
               irq_en_r <= avs_writedata[2];
            end
            4'd9:  iv_hi_r       <= avs_writedata;
            4'd10: iv_lo_r       <= avs_writedata;
            default: ;
         endcase
      end
   end

   // Sticky status bits (hardware set beats W1C), pending abort and the registered interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done_r          <= 1'b0;
         aborted_r       <= 1'b0;
         abort_pending_r <= 1'b0;
         irq_r           <= 1'b0;
      end else begin
         if (fin_s && !abort_pending_r)      done_r <= 1'b1;
         else if (w1c_s && avs_writedata[1]) done_r <= 1'b0;
         if (fin_s && abort_pending_r)       aborted_r <= 1'b1;
         else if (w1c_s && avs_writedata[2]) aborted_r <= 1'b0;
         if (fin_s)                          abort_pending_r <= 1'b0;
         else if (abort_wr_s)                abort_pending_r <= 1'b1;
         irq_r <= irq_en_r & (done_r | aborted_r);
      end
   end

   // Transfer datapath: pointers, block counters, plaintext capture and CBC chain value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_r    <= 32'h0;
         wr_ptr_r    <= 32'h0;
         remaining_r <= {CNT_W{1'b0}};
         done_cnt_r  <= {CNT_W{1'b0}};
         chain_r     <= 64'h0;
         pt_r        <= 64'h0;
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         if (start_s) begin
            remaining_r <= num_r;
            done_cnt_r  <= {CNT_W{1'b0}};
            chain_r     <= {iv_hi_r, iv_lo_r};
         end else if (state_r == WR1 && hs_s) begin
            remaining_r <= remaining_r - CNT_W'(32'd1);
            done_cnt_r  <= done_cnt_r + CNT_W'(32'd1);
            chain_r     <= ct_s;
         end
         if (state_r == RD0 && hs_s) pt_r[63:32] <= avm_readdata;
         if (state_r == RD1 && hs_s) pt_r[31:0]  <= avm_readdata;
      end
   end

   // Pointer look-ahead so the bus outputs can be registered from next-state values.
   always_comb begin
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               rd_ptr_nxt_s = src_r;
               wr_ptr_nxt_s = dst_r;
            end else begin
               rd_ptr_nxt_s = rd_ptr_r;
            end
         end
         RD0, RD1: begin
            if (hs_s) rd_ptr_nxt_s = rd_ptr_r + 32'd4;
            else      rd_ptr_nxt_s = rd_ptr_r;
         end
         WR0, WR1: begin
            if (hs_s) wr_ptr_nxt_s = wr_ptr_r + 32'd4;
            else      wr_ptr_nxt_s = wr_ptr_r;
         end
         default: rd_ptr_nxt_s = rd_ptr_r;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= IDLE;
      else          state_r <= nxt_state_s;
   end

   // FSM next-state logic; a pending abort is honoured at the next completed bus beat.
   always_comb begin
      nxt_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) nxt_state_s = (num_r == {CNT_W{1'b0}}) ? FINISH : RD0;
            else         nxt_state_s = IDLE;
         end
         RD0: begin
            if (hs_s) nxt_state_s = abort_pending_r ? FINISH : RD1;
            else      nxt_state_s = RD0;
         end
         RD1: begin
            if (hs_s) nxt_state_s = abort_pending_r ? FINISH : ENC_START;
            else      nxt_state_s = RD1;
         end
         ENC_START: nxt_state_s = ENC_WAIT;
         ENC_WAIT: begin
            if (eoc_s) nxt_state_s = WR0;
            else       nxt_state_s = ENC_WAIT;
         end
         WR0: begin
            if (hs_s) nxt_state_s = abort_pending_r ? FINISH : WR1;
            else      nxt_state_s = WR0;
         end
         WR1: begin
            if (hs_s) nxt_state_s = (abort_pending_r || last_blk_s) ? FINISH : RD0;
            else      nxt_state_s = WR1;
         end
         FINISH:  nxt_state_s = IDLE;
         default: nxt_state_s = IDLE;
      endcase
   end

   // FSM output decode from the next state, registered below.
   always_comb begin
      avm_read_nxt_s      = (nxt_state_s == RD0) || (nxt_state_s == RD1);
      avm_write_nxt_s     = (nxt_state_s == WR0) || (nxt_state_s == WR1);
      avm_address_nxt_s   = 32'h0;
      avm_writedata_nxt_s = 32'h0;
      if (avm_read_nxt_s)       avm_address_nxt_s = rd_ptr_nxt_s;
      else if (avm_write_nxt_s) avm_address_nxt_s = wr_ptr_nxt_s;
      else                      avm_address_nxt_s = 32'h0;
      if (nxt_state_s == WR0)      avm_writedata_nxt_s = ct_s[63:32];
      else if (nxt_state_s == WR1) avm_writedata_nxt_s = ct_s[31:0];
      else                         avm_writedata_nxt_s = 32'h0;
   end

   // Registered initiator outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avm_read_r      <= 1'b0;
         avm_write_r     <= 1'b0;
         avm_address_r   <= 32'h0;
         avm_writedata_r <= 32'h0;
      end else begin
         avm_read_r      <= avm_read_nxt_s;
         avm_write_r     <= avm_write_nxt_s;
         avm_address_r   <= avm_address_nxt_s;
         avm_writedata_r <= avm_writedata_nxt_s;
      end
   end

   assign avm_read      = avm_read_r;
   assign avm_write     = avm_write_r;
   assign avm_address   = avm_address_r;
   assign avm_writedata = avm_writedata_r;
   assign irq           = irq_r;

   // Target read mux.
   always_comb begin
      avs_readdata = 32'h0;
      case (reg_idx_s)
         4'd0:    avs_readdata = key_r[31:0];
         4'd1:    avs_readdata = key_r[63:32];
         4'd2:    avs_readdata = key_r[95:64];
         4'd3:    avs_readdata = key_r[127:96];
         4'd4:    avs_readdata = src_r;
         4'd5:    avs_readdata = dst_r;
         4'd6:    avs_readdata = 32'(num_r);
         4'd7:    avs_readdata = {29'h0, irq_en_r, mode_r, 1'b0};
         4'd8:    avs_readdata = {29'h0, aborted_r, done_r, busy_s};
         4'd9:    avs_readdata = iv_hi_r;
         4'd10:   avs_readdata = iv_lo_r;
         4'd11:   avs_readdata = 32'(done_cnt_r);
         default: avs_readdata = 32'h0;
      endcase
   end

endmodule
